// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the read-side stream consumer of the async FIFO.
package fifo_rd_stream_pkg;

  // Defaults shared with the FIFO so both ends agree on word and address width
  localparam int DSIZE_DEFAULT = 8;
  localparam int ASIZE_DEFAULT = 4;

  // Skid-buffer occupancy: how many words the stream side is holding
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // A buffer entry is {data, last}: data in the upper DSIZE bits, last flag in bit 0
  localparam int ENTRY_LAST_BIT = 0;
  localparam int ENTRY_DATA_LSB = 1;

endpackage

// File: rtl/fifo_rd_stream.sv
// Pops words from the async FIFO read port and re-presents them as a registered
// valid/ready stream through a 2-entry skid buffer, tagging packet ends and
// counting delivered words.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DSIZE   = DSIZE_DEFAULT,
  parameter int PKT_LEN = 4,
  parameter int CWIDTH  = 16
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              en,
  input  logic [DSIZE-1:0]  fifo_rdata,
  input  logic              fifo_rempty,
  output logic              fifo_rinc,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DSIZE-1:0]  m_data,
  output logic              m_last,
  output logic [CWIDTH-1:0] word_cnt
);

  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int EW = DSIZE + 1;

  occ_e            r_state;
  occ_e            w_nextState;
  logic [EW-1:0]   r_head;
  logic [EW-1:0]   r_tail;
  logic [BW-1:0]   r_beatIdx;
  logic [CWIDTH-1:0] r_wordCnt;

  logic            w_capture;
  logic            w_accept;
  logic            w_lastBit;
  logic [EW-1:0]   w_newEntry;
  logic            w_loadHead;
  logic            w_loadTail;
  logic            w_tailToHead;

  // Pop decision looks only at registered occupancy so m_ready never reaches the FIFO
  assign w_capture  = rrst_n & en & ~fifo_rempty & (r_state != OCC_TWO);
  assign w_accept   = (r_state != OCC_EMPTY) & m_ready;
  assign w_lastBit  = (r_beatIdx == BW'(PKT_LEN - 1));
  assign w_newEntry = {fifo_rdata, w_lastBit};

  assign fifo_rinc = w_capture;
  assign m_valid   = (r_state != OCC_EMPTY);
  assign m_data    = r_head[EW-1:ENTRY_DATA_LSB];
  assign m_last    = r_head[ENTRY_LAST_BIT];
  assign word_cnt  = r_wordCnt;

  // Occupancy register
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) r_state <= OCC_EMPTY;
    else         r_state <= w_nextState;
  end

  // Next occupancy and which buffer slot a captured or surviving word lands in
  always_comb begin
    w_nextState  = r_state;
    w_loadHead   = 1'b0;
    w_loadTail   = 1'b0;
    w_tailToHead = 1'b0;
    case (r_state)
      OCC_EMPTY: begin
        if (w_capture) begin
          w_nextState = OCC_ONE;
          w_loadHead  = 1'b1;
        end
      end
      OCC_ONE: begin
        if (w_capture && !w_accept) begin
          w_nextState = OCC_TWO;
          w_loadTail  = 1'b1;
        end else if (w_capture && w_accept) begin
          w_loadHead  = 1'b1;
        end else if (w_accept) begin
          w_nextState = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (w_accept) begin
          w_nextState  = OCC_ONE;
          w_tailToHead = 1'b1;
        end
      end
      default: w_nextState = OCC_EMPTY;
    endcase
  end

  // Head and tail entry storage; head always feeds the stream outputs
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_loadHead)        r_head <= w_newEntry;
      else if (w_tailToHead) r_head <= r_tail;
      if (w_loadTail)        r_tail <= w_newEntry;
    end
  end

  // Packet beat counter advances only on capture, so framing survives en dropping
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)        r_beatIdx <= '0;
    else if (w_capture) r_beatIdx <= w_lastBit ? '0 : r_beatIdx + BW'(1);
  end

  // Delivered-word count, wrapping silently
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)       r_wordCnt <= '0;
    else if (w_accept) r_wordCnt <= r_wordCnt + CWIDTH'(1);
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed plus randomized bench for fifo_rd_stream. A queue-based model of the
// FIFO and of the in-flight words predicts every output each cycle. A second
// instance with PKT_LEN=1 and CWIDTH=4 shares all inputs to cover framing
// and counter wrap corners.
module tb_fifo_rd_stream;

  logic        rclk;
  logic        rrstN;
  logic        en;
  logic [7:0]  fifoRdata;
  logic        fifoRempty;
  logic        mReady;

  logic        fifoRinc,  fifoRinc2;
  logic        mValid,    mValid2;
  logic [7:0]  mData,     mData2;
  logic        mLast,     mLast2;
  logic [15:0] wordCnt;
  logic [3:0]  wordCnt2;

  int nVectors;
  int nMiscompares;

  logic [7:0] srcQ[$];
  logic [8:0] outQ[$];
  logic [8:0] accLog[$];
  int popCount;
  int accCount;
  int rincSeen;
  int dutAccepts;

  fifo_rd_stream #(.DSIZE(8), .PKT_LEN(4), .CWIDTH(16)) dut (
    .rclk(rclk), .rrst_n(rrstN), .en(en), .fifo_rdata(fifoRdata),
    .fifo_rempty(fifoRempty), .fifo_rinc(fifoRinc), .m_valid(mValid),
    .m_ready(mReady), .m_data(mData), .m_last(mLast), .word_cnt(wordCnt)
  );

  fifo_rd_stream #(.DSIZE(8), .PKT_LEN(1), .CWIDTH(4)) dut2 (
    .rclk(rclk), .rrst_n(rrstN), .en(en), .fifo_rdata(fifoRdata),
    .fifo_rempty(fifoRempty), .fifo_rinc(fifoRinc2), .m_valid(mValid2),
    .m_ready(mReady), .m_data(mData2), .m_last(mLast2), .word_cnt(wordCnt2)
  );

  // Read clock
  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  // One comparison: counts it and reports a miscompare with tag and values
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    assert (obs === exp)
    else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle from a falling edge, check predictions, then advance the model
  task automatic applyStimulus(input logic enV, input logic readyV);
    logic expRinc, expValid, acc;
    logic [8:0] e;
    en         = enV;
    mReady     = readyV;
    fifoRempty = (srcQ.size() == 0);
    fifoRdata  = (srcQ.size() != 0) ? srcQ[0] : 8'($urandom);
    #1;
    expRinc  = enV && (srcQ.size() != 0) && (outQ.size() < 2);
    expValid = (outQ.size() != 0);
    acc      = expValid && readyV;
    checkOutput("rinc",   32'(fifoRinc),  32'(expRinc));
    checkOutput("valid",  32'(mValid),    32'(expValid));
    checkOutput("cnt",    32'(wordCnt),   32'(accCount % 65536));
    checkOutput("rinc2",  32'(fifoRinc2), 32'(expRinc));
    checkOutput("valid2", 32'(mValid2),   32'(expValid));
    checkOutput("cnt2",   32'(wordCnt2),  32'(accCount % 16));
    if (expValid) begin
      checkOutput("data",  32'(mData),  32'(outQ[0][8:1]));
      checkOutput("last",  32'(mLast),  32'(outQ[0][0]));
      checkOutput("data2", 32'(mData2), 32'(outQ[0][8:1]));
      checkOutput("last2", 32'(mLast2), 32'd1);
    end
    if (fifoRinc === 1'b1) rincSeen++;
    if (mValid === 1'b1 && readyV) dutAccepts++;
    @(posedge rclk);
    if (acc) begin
      e = outQ.pop_front();
      accLog.push_back(e);
      accCount++;
    end
    if (expRinc) begin
      e = {srcQ.pop_front(), ((popCount % 4) == 3)};
      outQ.push_back(e);
      popCount++;
    end
    @(negedge rclk);
  endtask

  // Run with en=1, m_ready=1 until everything is delivered (bounded)
  task automatic drainAll(input int limit);
    for (int c = 0; c < limit && (srcQ.size() != 0 || outQ.size() != 0); c++)
      applyStimulus(1'b1, 1'b1);
  endtask

  initial begin
    int base;
    nVectors = 0; nMiscompares = 0;
    popCount = 0; accCount = 0; rincSeen = 0; dutAccepts = 0;
    rrstN = 1'b0; en = 1'b1; mReady = 1'b1; fifoRempty = 1'b0; fifoRdata = 8'hA5;

    // Reset values while a pop would otherwise be possible
    #12;
    checkOutput("rstValid", 32'(mValid), 32'd0);
    checkOutput("rstData",  32'(mData),  32'd0);
    checkOutput("rstLast",  32'(mLast),  32'd0);
    checkOutput("rstCnt",   32'(wordCnt), 32'd0);
    checkOutput("rstRinc",  32'(fifoRinc), 32'd0);
    checkOutput("rstRinc2", 32'(fifoRinc2), 32'd0);
    @(negedge rclk);
    rrstN = 1'b1;

    // Eight framed words at full rate
    $display("[TB] streaming 0x11..0x18");
    for (int i = 0; i < 8; i++) srcQ.push_back(8'h11 + 8'(i));
    accLog.delete();
    drainAll(30);
    checkOutput("seqCount", 32'(accLog.size()), 32'd8);
    for (int i = 0; i < accLog.size() && i < 8; i++) begin
      checkOutput("seqData", 32'(accLog[i][8:1]), 32'h11 + 32'(i));
      checkOutput("seqLast", 32'(accLog[i][0]), 32'((i % 4) == 3));
    end
    checkOutput("seqCnt", 32'(wordCnt), 32'd8);

    // Backpressure: only two pops fit in the skid buffer
    $display("[TB] backpressure");
    for (int i = 0; i < 5; i++) srcQ.push_back(8'($urandom));
    base = rincSeen;
    for (int c = 0; c < 6; c++) applyStimulus(1'b1, 1'b0);
    checkOutput("bpPops", 32'(rincSeen - base), 32'd2);
    drainAll(30);

    // Drop en mid-packet, then resume
    $display("[TB] enable pause mid-packet");
    for (int i = 0; i < 10; i++) srcQ.push_back(8'($urandom));
    for (int c = 0; c < 10 && (popCount % 4) != 2; c++) applyStimulus(1'b1, 1'b1);
    base = rincSeen;
    for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b1);
    checkOutput("enPops", 32'(rincSeen - base), 32'd0);
    drainAll(40);

    // Alternating ready against a source that fills every other cycle
    $display("[TB] alternating ready");
    base = dutAccepts;
    begin
      int pushed;
      pushed = 0;
      for (int c = 0; c < 200; c++) begin
        if ((c % 2) == 0 && pushed < 64) begin
          srcQ.push_back(8'($urandom));
          pushed++;
        end
        applyStimulus(1'b1, (c % 2) == 0);
      end
    end
    checkOutput("altAccepts", 32'(dutAccepts - base), 32'd64);

    // Reset while two words are held
    $display("[TB] reset with full skid buffer");
    for (int i = 0; i < 3; i++) srcQ.push_back(8'($urandom));
    for (int c = 0; c < 6 && outQ.size() < 2; c++) applyStimulus(1'b1, 1'b0);
    en = 1'b1; fifoRempty = 1'b0;
    #2 rrstN = 1'b0;
    #1;
    checkOutput("midRstValid",  32'(mValid),   32'd0);
    checkOutput("midRstCnt",    32'(wordCnt),  32'd0);
    checkOutput("midRstData",   32'(mData),    32'd0);
    checkOutput("midRstRinc",   32'(fifoRinc), 32'd0);
    checkOutput("midRstValid2", 32'(mValid2),  32'd0);
    checkOutput("midRstCnt2",   32'(wordCnt2), 32'd0);
    outQ.delete();
    accLog.delete();
    popCount = 0;
    accCount = 0;
    @(negedge rclk);
    rrstN = 1'b1;

    // Seventeen words after reset: narrow counter wraps to 1
    $display("[TB] counter wrap");
    for (int i = 0; i < 16; i++) srcQ.push_back(8'($urandom));
    drainAll(60);
    checkOutput("wrapCnt2", 32'(wordCnt2), 32'd1);
    checkOutput("wrapCnt",  32'(wordCnt),  32'd17);

    // Randomized traffic
    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) != 0 && srcQ.size() < 16) srcQ.push_back(8'($urandom));
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom));
    end
    drainAll(60);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
